// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 message loader/padder: reads NUM_OF_WORDS words from memory and emits
// the padded message (0x80000000, zero fill, 64-bit bit length) over a valid/ready stream.
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last_word,
  output logic        out_last_block
);

  localparam int          N             = NUM_OF_WORDS;
  localparam int          T             = 16 * ((N + 18) / 16);
  localparam logic [15:0] N16           = 16'(N);
  localparam logic [15:0] LAST_MEM_J    = 16'(N - 1);
  localparam logic [15:0] LEN_HI_J      = 16'(T - 2);
  localparam logic [15:0] LAST_J        = 16'(T - 1);
  localparam logic [15:0] FINAL_BLOCK_J = 16'(T - 16);
  localparam logic [31:0] LEN_LO        = 32'(32 * N);

  typedef enum logic [1:0] {IDLE, STREAM, PAD} state_t;

  state_t      state, state_nxt;
  logic [15:0] base, rd_idx, j;
  logic [31:0] fifo_q [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  fifo_count;
  logic        inflight;
  logic [2:0]  occupancy;
  logic        accept, transfer, pop, push, issue;
  logic [31:0] pad_word;

  assign mem_clk   = clk;
  assign mem_we    = 1'b0;
  assign mem_addr  = base + rd_idx;

  assign accept    = (state == IDLE) && start;
  assign transfer  = out_valid && out_ready;
  assign pop       = (state == STREAM) && transfer;
  assign push      = inflight;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
  // A pop in the same cycle frees a slot, which keeps an unstalled stream at one word per cycle.
  assign issue     = (state == STREAM) && (rd_idx < N16) && (fifo_count != 2'd2) &&
                     (occupancy < (pop ? 3'd3 : 3'd2));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)                        state_nxt = STREAM;
      STREAM:  if (pop && (j == LAST_MEM_J))     state_nxt = PAD;
      PAD:     if (transfer && (j == LAST_J))    state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pad_word = 32'h0;
    if (j == N16)           pad_word = 32'h8000_0000;
    else if (j == LEN_HI_J) pad_word = 32'h0;
    else if (j == LAST_J)   pad_word = LEN_LO;
  end

  always_comb begin
    done           = 1'b0;
    out_valid      = 1'b0;
    out_data       = 32'h0;
    out_last_word  = 1'b0;
    out_last_block = 1'b0;
    unique case (state)
      IDLE:   done = 1'b1;
      STREAM: begin
        out_valid = (fifo_count != 2'd0);
        if (out_valid) out_data = fifo_q[rd_ptr];
      end
      PAD: begin
        out_valid = 1'b1;
        out_data  = pad_word;
      end
      default: done = 1'b1;
    endcase
    if (state != IDLE) begin
      out_last_word  = (j[3:0] == 4'hf);
      out_last_block = (j >= FINAL_BLOCK_J);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base       <= '0;
      rd_idx     <= '0;
      j          <= '0;
      inflight   <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
    end else if (accept) begin
      base       <= message_addr;
      rd_idx     <= '0;
      j          <= '0;
      inflight   <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
    end else begin
      // The registered memory returns data one edge after the address, so the flag marks a pending push.
      inflight <= issue;
      if (issue)    rd_idx <= rd_idx + 16'd1;
      if (transfer) j      <= j + 16'd1;
      if (push)     wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; fifo_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= mem_read_data;
  end

endmodule
